seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Parametrised multiplexed seven-segment display driver for N digits. It sits downstream of the UART receiver. It captures received bytes into a shift buffer of hex nibbles, or an error pattern on framing/parity error. It time-multiplexes the digits with a programmable dwell time and a blanking gap between digits, and drives active-low anodes and segments.

## Interface
- DIGITS, 4, number of digits; must be even and ≥2 (one byte fills two digits)
- DWELL, 16, clocks each anode is held active per slot; ≥1
- BLANK, 4, clocks all anodes are off at the start of each slot, for anti-ghosting; ≥1
- ERR_CODE, 4'hA, nibble written to every digit on a receive error
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte from the UART receiver
- rx_valid  in  1  byte-valid strobe, synchronous to clk
- ferror  in  1  framing error, qualified by rx_valid
- perror  in  1  parity error, qualified by rx_valid
- clear  in  1  synchronous clear of the display buffer and error flag
- an  out  DIGITS  anodes, active low; an[DIGITS-1] is the leftmost digit
- seg  out  7  segments, active low, ordered {a,b,c,d,e,f,g} on bits [6:0]
- error_flag  out  1  sticky receive-error indicator

## Operation
- Display buffer: DIGITS×4 bits. Nibble i drives digit i.
- Reset or clear sets every nibble to 4'hF and sets error_flag to 0. If clear and a strobe occur in the same cycle, clear wins.
- Strobe detection: a strobe is the rising edge of rx_valid (rx_valid=1 now, 0 in the previous cycle). A level held high produces exactly one strobe.
- Strobe with ferror|perror=1: every nibble becomes ERR_CODE and error_flag becomes 1.
- Strobe with no error: the buffer shifts left by 8 bits and rx_data enters bits [7:0]. rx_data[7:4] goes to digit 1 and rx_data[3:0] goes to digit 0. error_flag becomes 0.
- Scan state: idx (digit, ⌈log2 DIGITS⌉ bits) and cnt (slot counter, 0..BLANK+DWELL-1). Reset values are idx=DIGITS-1 and cnt=0.
- cnt increments every clock and wraps to 0 at BLANK+DWELL-1.
- On a cnt wrap, idx decrements; from 0 it wraps to DIGITS-1.
- Nibble snapshot: at cnt==0 the buffer nibble for idx is captured into a char register. A buffer change mid-slot appears at the next visit to that digit, so there is no tearing.
- Outputs are registered from the scan state:
  - cnt<BLANK: an = all 1, seg = 7'b1111111.
  - cnt≥BLANK: an has only bit idx = 0, seg = decode(char).
- At most one anode is low in any cycle.
- Decoder, standard hex, active low, examples:
  - 0 → 0000001
  - 1 → 1001111
  - 5 → 0100100
  - A → 0001000
  - F → 0111000
  - all 16 codes are defined.

## Timing
- Reset values: an = all 1, seg = 1111111, error_flag = 0, buffer = all F, idx = DIGITS-1, cnt = 0, char = F.
- Output latency: one clock after the scan state (registered).
- Default timing, edges counted from the first rising edge after reset release:
  - an[3] is low after edges 5..20, which is 16 clocks.
  - Blank after edges 21..24.
  - an[2] is low after edges 25..40, and so on.
  - Frame = DIGITS×(BLANK+DWELL) = 80 clocks.
- Buffer and error_flag update on the clock edge that samples the strobe, so the latency from strobe to buffer is 1 clock. The earliest visible change is at the next snapshot of the affected digit.
- Reset asserted mid-slot: all outputs go to their reset values immediately (asynchronously). The scan restarts at digit DIGITS-1, blank phase.
- rx_valid re-asserted on the cycle after it drops: counts as a new strobe.

## Test plan
- Reset then idle 80 clocks, defaults:
  - an cycles 0111, 1111, 1011, 1111, 1101, 1111, 1110, 1111.
  - Active windows are 16 clocks and blank windows are 4 clocks.
  - seg is 0111000 in every active window and 1111111 in every blank window.
- Send bytes 8'h12 then 8'h34 as one-cycle strobes. After the next full frame, the digits left to right show 1,2,3,4: seg 1001111, 0010010, 0000110, 1001100. error_flag = 0.
- Send 8'h12, then a strobe with perror=1:
  - all digits show A (0001000) and error_flag = 1.
  - a following good 8'h05 gives A,A,0,5 and error_flag = 0.
- Hold rx_valid high for 10 cycles with rx_data = 8'h77: exactly one shift occurs, leaving F,F,7,7. Assert clear together with a strobe: result is all F.
- Write a byte while an[1] is active: the digit keeps its old value until its next slot. Assert reset mid-slot: an goes to 1111 and seg to 1111111 at once.
- DIGITS=6, DWELL=3, BLANK=1: frame = 24 clocks, only one anode low at a time, and an[5] is the first digit active after reset.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment driver: captures received bytes as hex nibbles and
// scans DIGITS active-low anodes with a blanking gap ahead of every dwell window.
module seven_seg_scan_driver #(
  parameter int         DIGITS   = 4,
  parameter int         DWELL    = 16,
  parameter int         BLANK    = 4,
  parameter logic [3:0] ERR_CODE = 4'hA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              ferror,
  input  logic              perror,
  input  logic              clear,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              error_flag
);

  localparam int SLOT  = BLANK + DWELL;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic                   rx_valid_p0;
  logic                   strobe;
  logic [DIGITS-1:0][3:0] buf_p0;
  logic [DIGITS-1:0][3:0] buf_shift;
  logic [CNT_W-1:0]       cnt_p0;
  logic [IDX_W-1:0]       idx_p0;
  logic [3:0]             char_p0;
  logic [DIGITS-1:0]      an_next;

  assign strobe = rx_valid & ~rx_valid_p0;

  always_comb begin
    buf_shift    = buf_p0;
    for (int i = DIGITS - 1; i >= 2; i--) begin
      buf_shift[i] = buf_p0[i-2];
    end
    buf_shift[1] = rx_data[7:4];
    buf_shift[0] = rx_data[3:0];
  end

  // Stage p0: receive capture into the display buffer (clear beats a strobe)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_p0 <= 1'b0;
      buf_p0      <= '1;
      error_flag  <= 1'b0;
    end else begin
      rx_valid_p0 <= rx_valid;
      if (clear) begin
        buf_p0     <= '1;
        error_flag <= 1'b0;
      end else if (strobe) begin
        if (ferror | perror) begin
          buf_p0     <= {DIGITS{ERR_CODE}};
          error_flag <= 1'b1;
        end else begin
          buf_p0     <= buf_shift;
          error_flag <= 1'b0;
        end
      end
    end
  end

  // Stage p0: scan state; the nibble is frozen at slot start so it cannot tear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0  <= '0;
      idx_p0  <= IDX_LAST;
      char_p0 <= 4'hF;
    end else begin
      if (cnt_p0 == CNT_LAST) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == '0) ? IDX_LAST : idx_p0 - 1'b1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
      if (cnt_p0 == '0) begin
        char_p0 <= buf_p0[idx_p0];
      end
    end
  end

  always_comb begin
    an_next = '1;
    if (cnt_p0 >= CNT_BLANK) begin
      an_next[idx_p0] = 1'b0;
    end
  end

  // Stage p1: registered anode and segment drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= 7'b1111111;
    end else begin
      an  <= an_next;
      seg <= (cnt_p0 < CNT_BLANK) ? 7'b1111111 : seg_decode(char_p0);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: default 4-digit instance plus a
// 6-digit / short-slot instance sharing the same clock and inputs.
module tb_seven_seg_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid, ferror, perror, clear;
  logic [3:0] an;
  logic [6:0] seg;
  logic       error_flag;
  logic [5:0] an2;
  logic [6:0] seg2;
  logic       error_flag2;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111, SA = 7'b0001000, SF = 7'b0111000;
  localparam logic [6:0] SOFF = 7'b1111111;

  always #5 clk = ~clk;

  seven_seg_scan_driver dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ferror(ferror), .perror(perror), .clear(clear),
    .an(an), .seg(seg), .error_flag(error_flag)
  );

  seven_seg_scan_driver #(.DIGITS(6), .DWELL(3), .BLANK(1)) dut6 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ferror(ferror), .perror(perror), .clear(clear),
    .an(an2), .seg(seg2), .error_flag(error_flag2)
  );

  always @(negedge clk) begin
    if ($countones(~an) > 1 || $countones(~an2) > 1) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic fe, input logic pe);
    @(negedge clk);
    rx_data = d; ferror = fe; perror = pe; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; ferror = 1'b0; perror = 1'b0;
  endtask

  // Edge k counts from the first rising edge after reset release.
  task automatic scan_checks(input string pfx);
    logic [3:0] ea;
    logic [6:0] es;
    logic [5:0] ea2;
    bit         do4, do6;
    for (int k = 1; k <= 86; k++) begin
      @(posedge clk); #1;
      do4 = 1'b1;
      ea  = 4'hF;
      es  = SOFF;
      case (k)
        1, 4, 21, 24, 81: begin ea = 4'hF;    es = SOFF; end
        5, 20, 85:        begin ea = 4'b0111; es = SF;   end
        25, 40:           begin ea = 4'b1011; es = SF;   end
        45:               begin ea = 4'b1101; es = SF;   end
        65, 80:           begin ea = 4'b1110; es = SF;   end
        default:          do4 = 1'b0;
      endcase
      if (do4) begin
        chk($sformatf("%s_an_e%0d", pfx, k), 32'(an), 32'(ea));
        chk($sformatf("%s_seg_e%0d", pfx, k), 32'(seg), 32'(es));
      end
      do6 = 1'b1;
      ea2 = 6'h3F;
      case (k)
        1, 5, 25: ea2 = 6'b111111;
        2, 4, 26: ea2 = 6'b011111;
        6:        ea2 = 6'b101111;
        22:       ea2 = 6'b111110;
        default:  do6 = 1'b0;
      endcase
      if (do6) chk($sformatf("%s_an6_e%0d", pfx, k), 32'(an2), 32'(ea2));
    end
  endtask

  task automatic capture(output logic [27:0] s);
    s = '1;
    for (int c = 0; c < 160; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        if (an == ~(4'b0001 << d)) s[d*7 +: 7] = seg;
      end
    end
  endtask

  task automatic wait_an(input logic [3:0] t, input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (an !== t && n < 300);
    chk(tag, 32'(an), 32'(t));
  endtask

  logic [27:0] s;

  initial begin
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0;
    ferror = 1'b0; perror = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'(SOFF));
    chk("rst_flag", 32'(error_flag), 32'h0);
    chk("rst_an6", 32'(an2), 32'h3F);
    reset = 1'b0;
    scan_checks("idle");

    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    chk("flag_good", 32'(error_flag), 32'h0);
    capture(s);
    chk("digits_1234", 32'(s), 32'({S1, S2, S3, S4}));

    send(8'h12, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    chk("flag_perr", 32'(error_flag), 32'h1);
    capture(s);
    chk("digits_err", 32'(s), 32'({SA, SA, SA, SA}));
    send(8'h05, 1'b0, 1'b0);
    chk("flag_recover", 32'(error_flag), 32'h0);
    capture(s);
    chk("digits_aa05", 32'(s), 32'({SA, SA, S0, S5}));
    send(8'h00, 1'b1, 1'b0);
    chk("flag_ferr", 32'(error_flag), 32'h1);

    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("flag_clear", 32'(error_flag), 32'h0);
    @(negedge clk); rx_data = 8'h77; rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    capture(s);
    chk("digits_hold", 32'(s), 32'({SF, SF, S7, S7}));
    send(8'h00, 1'b1, 1'b0);
    @(negedge clk); rx_data = 8'h99; rx_valid = 1'b1; clear = 1'b1;
    @(negedge clk); rx_valid = 1'b0; clear = 1'b0;
    chk("flag_clr_strobe", 32'(error_flag), 32'h0);
    capture(s);
    chk("digits_clr_strobe", 32'(s), 32'({SF, SF, SF, SF}));

    wait_an(4'b1101, "wait_an1");
    send(8'h5A, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("midslot_an", 32'(an), 32'(4'b1101));
    chk("midslot_seg", 32'(seg), 32'(SF));
    capture(s);
    chk("digits_midslot", 32'(s), 32'({SF, SF, S5, SA}));

    send(8'h00, 1'b0, 1'b1);
    wait_an(4'b1011, "wait_an2");
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'(SOFF));
    chk("async_flag", 32'(error_flag), 32'h0);
    @(negedge clk); reset = 1'b0;
    scan_checks("rerun");

    chk("onehot", 32'(viol), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
